// File: rtl/l2_write_buffer.sv
// Line-granular write buffer between the L1 arbiter and L2: acks writes at once, drains FIFO-order when idle.
// Define WBUF_READ_FWD_EN to serve read hits from the buffer; otherwise reads first drain the buffer.
module l2_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int LW    = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_read,
  input  logic          up_write,
  input  logic [AW-1:0] up_addr,
  input  logic [LW-1:0] up_wdata,
  output logic [LW-1:0] up_rdata,
  output logic          up_resp,
  output logic          dn_read,
  output logic          dn_write,
  output logic [AW-1:0] dn_addr,
  output logic [LW-1:0] dn_wdata,
  input  logic [LW-1:0] dn_rdata,
  input  logic          dn_resp,
  output logic          wb_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    L2_RD,
    DRAIN,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic [LW-1:0]   rd_data_q, rd_data_d;

  logic [AW-1:0]   addr_q [DEPTH];
  logic [LW-1:0]   line_q [DEPTH];

  logic            hit;
  logic [PW-1:0]   hit_idx;
  logic            full;

  logic            do_push;
  logic            do_merge;
  logic            do_pop;
  logic            do_rd_hit;
  logic            do_miss;
  logic            do_l2_cap;

  // Buffered addresses are unique, so at most one entry can match.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == up_addr)) begin
        hit     = 1'b1;
        hit_idx = PW'(i);
      end
    end
  end

  assign full     = (count_q == CW'(DEPTH));
  assign wb_empty = (count_q == '0);

  // NOTE: every signal driven here gets a default first, otherwise an
  // unassigned path would infer a latch.
  always_comb begin
    state_d   = state_q;
    do_push   = 1'b0;
    do_merge  = 1'b0;
    do_pop    = 1'b0;
    do_rd_hit = 1'b0;
    do_miss   = 1'b0;
    do_l2_cap = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (up_write) begin
          if (hit) begin
            do_merge = 1'b1;
            state_d  = DONE;
          end else if (!full) begin
            do_push = 1'b1;
            state_d = DONE;
          end else begin
            state_d = DRAIN;
          end
        end else if (up_read) begin
`ifdef WBUF_READ_FWD_EN
          if (hit) begin
            do_rd_hit = 1'b1;
            state_d   = DONE;
          end else begin
            do_miss = 1'b1;
            state_d = L2_RD;
          end
`else
          // Without forwarding, L2 must see every buffered line before the read.
          if (!wb_empty) begin
            state_d = DRAIN;
          end else begin
            do_miss = 1'b1;
            state_d = L2_RD;
          end
`endif
        end else if (!wb_empty) begin
          state_d = DRAIN;
        end
      end
      L2_RD: begin
        if (dn_resp) begin
          do_l2_cap = 1'b1;
          state_d   = DONE;
        end
      end
      DRAIN: begin
        if (dn_resp) begin
          do_pop  = 1'b1;
          state_d = IDLE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Push and pop never coincide: they come from different states.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    if (do_push) begin
      tail_d          = tail_q + 1'b1;
      count_d         = count_q + 1'b1;
      valid_d[tail_q] = 1'b1;
    end
    if (do_pop) begin
      head_d          = head_q + 1'b1;
      count_d         = count_q - 1'b1;
      valid_d[head_q] = 1'b0;
    end
  end

  always_comb begin
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    if (do_miss) begin
      rd_addr_d = up_addr;
    end
    if (do_rd_hit) begin
      rd_data_d = line_q[hit_idx];
    end else if (do_l2_cap) begin
      rd_data_d = dn_rdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      valid_q   <= '0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
    end
  end

  // NOTE: the entry payload has no reset; the valid bits alone decide
  // whether an entry is meaningful, so clearing the storage buys nothing.
  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_q[tail_q] <= up_addr;
      line_q[tail_q] <= up_wdata;
    end
    if (do_merge) begin
      line_q[hit_idx] <= up_wdata;
    end
  end

  assign up_resp  = (state_q == DONE);
  assign up_rdata = rd_data_q;
  assign dn_read  = (state_q == L2_RD);
  assign dn_write = (state_q == DRAIN);

  always_comb begin
    dn_addr  = '0;
    dn_wdata = '0;
    if (dn_read) begin
      dn_addr = rd_addr_q;
    end else if (dn_write) begin
      dn_addr  = addr_q[head_q];
      dn_wdata = line_q[head_q];
    end
  end

endmodule

// File: tb/tb_l2_write_buffer.sv
// Scoreboard bench for l2_write_buffer: expected L2 writes and read data are queued
// when stimulus is accepted and compared when the DUT emits them.
module tb_l2_write_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 16;
  localparam int LW    = 128;
  localparam logic [LW-1:0] ZERO = '0;
  localparam logic [LW-1:0] ONE  = LW'(1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          up_read;
  logic          up_write;
  logic [AW-1:0] up_addr;
  logic [LW-1:0] up_wdata;
  logic [LW-1:0] up_rdata;
  logic          up_resp;
  logic          dn_read;
  logic          dn_write;
  logic [AW-1:0] dn_addr;
  logic [LW-1:0] dn_wdata;
  logic [LW-1:0] dn_rdata;
  logic          dn_resp;
  logic          wb_empty;

  l2_write_buffer #(.DEPTH(DEPTH), .AW(AW), .LW(LW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_read  (up_read),
    .up_write (up_write),
    .up_addr  (up_addr),
    .up_wdata (up_wdata),
    .up_rdata (up_rdata),
    .up_resp  (up_resp),
    .dn_read  (dn_read),
    .dn_write (dn_write),
    .dn_addr  (dn_addr),
    .dn_wdata (dn_wdata),
    .dn_rdata (dn_rdata),
    .dn_resp  (dn_resp),
    .wb_empty (wb_empty)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
  } wr_t;

  wr_t           exp_wr[$];
  logic [LW-1:0] exp_rd[$];
  logic [LW-1:0] l2_mem [logic [AW-1:0]];

  int            checks   = 0;
  int            failures = 0;
  int            l2_lat   = 1;
  int            wr_resp_edge = 0;
  int            rd_resp_edge = 0;
  int            n_dn_wr  = 0;
  int            n_dn_rd  = 0;
  logic [AW-1:0] last_rd_addr = '0;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Bench copy of buffer contents: same-address writes merge, new ones append.
  function automatic void model_write(input logic [AW-1:0] a, input logic [LW-1:0] d);
    foreach (exp_wr[i]) begin
      if (exp_wr[i].addr == a) begin
        exp_wr[i].data = d;
        return;
      end
    end
    exp_wr.push_back('{addr: a, data: d});
  endfunction

  // L2 model: answers each request l2_lat observations after it appears.
  initial begin : l2_model
    int wait_cnt;
    wait_cnt = 0;
    dn_resp  = 1'b0;
    dn_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || dn_resp) begin
        dn_resp  = 1'b0;
        wait_cnt = 0;
      end else if (dn_read || dn_write) begin
        if (wait_cnt >= l2_lat - 1) begin
          dn_resp  = 1'b1;
          wait_cnt = 0;
          if (dn_write) begin
            n_dn_wr++;
            wr_resp_edge = cyc + 1;
            check("dn_wr_expected", LW'(exp_wr.size() != 0), ONE);
            if (exp_wr.size() != 0) begin
              wr_t e;
              e = exp_wr.pop_front();
              check("dn_wr_addr", LW'(dn_addr), LW'(e.addr));
              check("dn_wr_data", dn_wdata, e.data);
            end
            l2_mem[dn_addr] = dn_wdata;
          end else begin
            n_dn_rd++;
            rd_resp_edge = cyc + 1;
            last_rd_addr = dn_addr;
            dn_rdata = l2_mem.exists(dn_addr) ? l2_mem[dn_addr] : {8{dn_addr}};
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic wait_resp(output int seen);
    seen = -1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (up_resp) begin
        seen = cyc;
        break;
      end
    end
    if (seen < 0) check("up_resp_seen", LW'(up_resp), ONE);
  endtask

  // mode 0: no timing check; 1: one-cycle latency; 2: two cycles after drain dn_resp.
  task automatic do_write(input logic [AW-1:0] a, input logic [LW-1:0] d, input int mode);
    int t0, seen;
    up_addr  = a;
    up_wdata = d;
    up_write = 1'b1;
    t0       = cyc;
    wait_resp(seen);
    up_write = 1'b0;
    if (seen >= 0) begin
      model_write(a, d);
      if (mode == 1) check("wr_latency", LW'(seen - t0), ONE);
      if (mode == 2) check("wr_forced_latency", LW'(seen - wr_resp_edge), ONE);
    end
    @(posedge clk);
    #1;
  endtask

  // mode 1: one-cycle hit latency; 2: up_resp in the cycle after dn_resp.
  task automatic do_read(input logic [AW-1:0] a, input logic [LW-1:0] d, input int mode);
    int t0, seen;
    exp_rd.push_back(d);
    up_addr = a;
    up_read = 1'b1;
    t0      = cyc;
    wait_resp(seen);
    up_read = 1'b0;
    if (seen >= 0) begin
      check("rd_data", up_rdata, exp_rd.pop_front());
      if (mode == 1) check("rd_hit_latency", LW'(seen - t0), ONE);
      if (mode == 2) check("rd_miss_latency", LW'(seen - rd_resp_edge), ZERO);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (wb_empty && !dn_write) break;
    end
    check("wb_empty", LW'(wb_empty), ONE);
    check("wr_queue_drained", LW'(exp_wr.size()), ZERO);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int w0, r0;
    up_read  = 1'b0;
    up_write = 1'b0;
    up_addr  = '0;
    up_wdata = '0;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_up_resp", LW'(up_resp), ZERO);
    check("rst_up_rdata", up_rdata, ZERO);
    check("rst_dn_read", LW'(dn_read), ZERO);
    check("rst_dn_write", LW'(dn_write), ZERO);
    check("rst_dn_addr", LW'(dn_addr), ZERO);
    check("rst_wb_empty", LW'(wb_empty), ONE);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single write, drained when idle.
    l2_lat = 4;
    w0 = n_dn_wr;
    do_write(16'h1230, 128'hAAAA_0000_1111_2222_3333_4444_5555_6666, 1);
    wait_empty();
    check("t1_dn_wr_count", LW'(n_dn_wr - w0), ONE);

    // Read right after a write to the same line.
    l2_lat = 2;
    r0 = n_dn_rd;
    do_write(16'h0040, 128'hBBBB_1234_5678_9ABC_DEF0_0FED_CBA9_8765, 1);
`ifdef WBUF_READ_FWD_EN
    do_read(16'h0040, 128'hBBBB_1234_5678_9ABC_DEF0_0FED_CBA9_8765, 1);
    check("t2_no_dn_read", LW'(n_dn_rd - r0), ZERO);
`else
    do_read(16'h0040, 128'hBBBB_1234_5678_9ABC_DEF0_0FED_CBA9_8765, 0);
    check("t2_one_dn_read", LW'(n_dn_rd - r0), ONE);
    check("t2_drained_first", LW'(exp_wr.size()), ZERO);
`endif
    wait_empty();

    // Back-to-back writes to one line merge into a single drain.
    w0 = n_dn_wr;
    do_write(16'h0080, 128'hCCCC_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC, 1);
    do_write(16'h0080, 128'hDDDD_DDDD_DDDD_DDDD_DDDD_DDDD_DDDD_DDDD, 1);
    wait_empty();
    check("t3_single_drain", LW'(n_dn_wr - w0), ONE);

    // Fill the buffer, then one more write forces a drain of the oldest entry.
    l2_lat = 3;
    w0 = n_dn_wr;
    for (int i = 0; i < DEPTH; i++) begin
      do_write(AW'(i * 16), {32'h5EED_0000, 32'(i), 32'(i * 3), 32'hCAFE_0000}, 1);
    end
    do_write(16'h0050, 128'h5555_0050_5555_0050_5555_0050_5555_0050, 2);
    wait_empty();
    check("t4_drain_count", LW'(n_dn_wr - w0), LW'(DEPTH + 1));

    // Read miss served by L2.
    l2_lat = 6;
    r0 = n_dn_rd;
    l2_mem[16'h0900] = 128'hEEEE_0900_0123_4567_89AB_CDEF_EEEE_0900;
    do_read(16'h0900, 128'hEEEE_0900_0123_4567_89AB_CDEF_EEEE_0900, 2);
    check("t5_dn_rd_addr", LW'(last_rd_addr), LW'(16'h0900));
    check("t5_one_dn_read", LW'(n_dn_rd - r0), ONE);

    // Reset in the middle of a drain.
    l2_lat = 50;
    do_write(16'h0A00, 128'hF00D_F00D_F00D_F00D_F00D_F00D_F00D_F00D, 1);
    for (int i = 0; i < 20; i++) begin
      if (dn_write) break;
      @(posedge clk);
      #1;
    end
    check("t6_drain_started", LW'(dn_write), ONE);
    w0 = n_dn_wr;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_dn_write", LW'(dn_write), ZERO);
    check("t6_rst_dn_read", LW'(dn_read), ZERO);
    check("t6_rst_dn_addr", LW'(dn_addr), ZERO);
    check("t6_rst_dn_wdata", dn_wdata, ZERO);
    check("t6_rst_up_resp", LW'(up_resp), ZERO);
    check("t6_rst_wb_empty", LW'(wb_empty), ONE);
    check("t6_rst_up_rdata", up_rdata, ZERO);
    exp_wr.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("t6_post_wb_empty", LW'(wb_empty), ONE);
    check("t6_post_dn_write", LW'(dn_write), ZERO);
    check("t6_no_pop", LW'(n_dn_wr - w0), ZERO);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
